// File: rtl/data_mem_lsu.sv
// data_mem_lsu: word-organised data memory behind a byte-addressed load/store
// front end. One request outstanding, valid/ready on both request and response.
// Stores commit on the acceptance edge; loads capture and extend the selected
// lanes at acceptance and present them READ_LAT edges later.
module data_mem_lsu #(
   parameter int DEPTH    = 16384,
   parameter int ADDR_W   = 32,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [31:0]       rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;

   logic [31:0]       mem [DEPTH];

   logic              accept;
   logic [ADDR_W-3:0] word_idx;
   logic [IDX_W-1:0]  mem_idx;
   logic [1:0]        lane;
   logic              out_of_range;
   logic              req_err;
   logic [3:0]        byte_en;
   logic [31:0]       wdata_rep;
   logic [31:0]       rd_word;
   logic [7:0]        rd_byte;
   logic [15:0]       rd_half;
   logic [31:0]       load_result;

   assign req_ready = (state_q == S_IDLE) && !rst;
   assign accept    = req_valid && req_ready;
   assign word_idx  = req_addr[ADDR_W-1:2];
   assign mem_idx   = word_idx[IDX_W-1:0];
   assign lane      = req_addr[1:0];
   // Upper address bits are part of the range check, so nothing aliases.
   assign out_of_range = 64'(word_idx) >= 64'(DEPTH);
   assign rd_word   = mem[mem_idx];

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

   // Classify the request: bad size, misalignment or word index past DEPTH.
   always_comb begin
      req_err = 1'b0;
      case (req_size)
         2'b00:   req_err = 1'b0;
         2'b01:   req_err = req_addr[0];
         2'b10:   req_err = (lane != 2'b00);
         default: req_err = 1'b1;
      endcase
      if (out_of_range) begin
         req_err = 1'b1;
      end else begin
         req_err = req_err;
      end
   end

   // Byte-lane enables and store data replicated onto every lane it may hit.
   always_comb begin
      byte_en   = 4'b0000;
      wdata_rep = 32'h0000_0000;
      case (req_size)
         2'b00: begin
            byte_en   = 4'b0001 << lane;
            wdata_rep = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            byte_en   = lane[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{req_wdata[15:0]}};
         end
         2'b10: begin
            byte_en   = 4'b1111;
            wdata_rep = req_wdata;
         end
         default: begin
            byte_en   = 4'b0000;
            wdata_rep = 32'h0000_0000;
         end
      endcase
   end

   // Lane selection and sign/zero extension of the word read at acceptance.
   always_comb begin
      rd_byte     = rd_word[8*lane +: 8];
      rd_half     = lane[1] ? rd_word[31:16] : rd_word[15:0];
      load_result = 32'h0000_0000;
      if (req_we || req_err) begin
         load_result = 32'h0000_0000;
      end else begin
         case (req_size)
            2'b00:   load_result = req_unsigned ? {24'h00_0000, rd_byte}
                                                : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   load_result = req_unsigned ? {16'h0000, rd_half}
                                                : {{16{rd_half[15]}}, rd_half};
            2'b10:   load_result = rd_word;
            default: load_result = 32'h0000_0000;
         endcase
      end
   end

   // Store commit on the acceptance edge; contents are not affected by reset.
   always_ff @(posedge clk) begin
      if (accept && req_we && !req_err) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
               mem[mem_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
         end
      end
   end

   // FSM next state: every accepted request waits cnt edges, then responds.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_WAIT;
               cnt_d   = req_we ? 3'd1 : 3'(READ_LAT);
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (cnt_q <= 3'd1) begin
               state_d = S_RESP;
               cnt_d   = 3'd0;
            end else begin
               cnt_d   = cnt_q - 3'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RESP;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
         end
      endcase
   end

   // Response outputs: capture result at acceptance, hold it until handshake.
   always_comb begin
      rsp_valid_d = (state_d == S_RESP);
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      if (accept) begin
         rsp_rdata_d = load_result;
         rsp_err_d   = req_err;
      end else begin
         rsp_rdata_d = rsp_rdata_q;
         rsp_err_d   = rsp_err_q;
      end
   end

   // State and response registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 3'd0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0000_0000;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

endmodule
